// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC register and decode.
//   Issues one instruction-memory read at a time from the current PC, pulses
//   the PC write enable for each issued read, and buffers {pc, word} pairs
//   in a DEPTH-entry FIFO that decode drains with a valid/ready handshake.
//   A flush discards buffered entries and any response still in flight.
//
// Ports:
//   clk         rising-edge clock
//   if_rst      synchronous active-high reset
//   if_pc       current PC from the PC register
//   if_pc_we    PC register load enable (one pulse per issued read)
//   if_flush    redirect: drop buffered and in-flight fetches
//   imem_addr   word-aligned fetch address (0 when not issuing)
//   imem_rd     read strobe, one cycle per request
//   imem_dout   returned instruction word
//   imem_valid  imem_dout valid this cycle
//   ir, ir_pc   instruction and its PC at the FIFO head
//   ir_valid    FIFO non-empty
//   ir_ready    decode accepts the head entry this cycle
module instr_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        if_rst,
  input  logic [31:0] if_pc,
  output logic        if_pc_we,
  input  logic        if_flush,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_dout,
  input  logic        imem_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // WAIT: one read outstanding, response will be kept.
  // DISCARD: one read outstanding, response will be dropped (post-flush).
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fentry_t;

  state_t         state, state_nxt;
  fentry_t        fifo [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [AW:0]    count;
  logic [31:0]    req_pc;
  logic           issue, push, pop;

  // Issue needs a guaranteed free slot for the response: with a single
  // outstanding read, count<DEPTH at issue time means the push always fits.
  // Reset overrides everything, so nothing issues while it is asserted.
  always_comb begin
    issue = (state == IDLE) && (count < FULL) && !if_flush && !if_rst;
    push  = (state == WAIT) && imem_valid && !if_flush;
    pop   = ir_valid && ir_ready && !if_flush;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (if_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = WAIT;
      // A response coinciding with a flush is simply dropped; otherwise the
      // flush turns the outstanding read into one that must be swallowed.
      WAIT:    if (imem_valid)    state_nxt = IDLE;
               else if (if_flush) state_nxt = DISCARD;
      // Further flushes here change nothing: still waiting for the stale word.
      DISCARD: if (imem_valid)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    imem_rd   = issue;
    if_pc_we  = issue;
    imem_addr = issue ? {if_pc[31:2], 2'b00} : 32'h0;
  end

  // ---------------- FIFO and request PC ----------------
  // Storage is cleared on reset so the head outputs are defined (zero)
  // even while empty.
  always_ff @(posedge clk) begin
    if (if_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      req_pc <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (if_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) req_pc <= if_pc;
      if (push) begin
        fifo[wr_ptr] <= '{pc: req_pc, word: imem_dout};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    ir       = fifo[rd_ptr].word;
    ir_pc    = fifo[rd_ptr].pc;
    ir_valid = (count != '0);
  end

  // A push into a full FIFO would mean the single-outstanding rule broke.
  a_no_overflow: assert property (@(posedge clk) disable iff (if_rst)
    !(push && !pop && count == FULL));

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the PC register. Consumes the current PC, issues instruction-memory reads, and advances the PC by pulsing its write enable on each accepted request.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports a flush on branch/jump redirect, including dropping an in-flight memory response.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- if_rst  input  1  synchronous, active-high reset.
- if_pc  input  32  current PC from PC register pc_count.
- if_pc_we  output  1  write enable to PC register; PC loads next-PC value.
- if_flush  input  1  redirect: discard buffered and in-flight fetches.
- imem_addr  output  32  word-aligned fetch address.
- imem_rd  output  1  read request strobe, one cycle per request.
- imem_dout  input  32  instruction word returned by memory.
- imem_valid  input  1  imem_dout valid this cycle.
- ir  output  32  instruction at FIFO head.
- ir_pc  output  32  PC of instruction at FIFO head.
- ir_valid  output  1  FIFO non-empty.
- ir_ready  input  1  decode accepts head this cycle.

Behaviour:
- One clock domain. if_rst is synchronous and active-high, sampled on the clk rising edge, and overrides all other inputs.
- Reset values:
  - state=IDLE, FIFO count=0, read/write pointers=0.
  - if_pc_we=0, imem_rd=0, ir_valid=0.
  - ir=0, ir_pc=0, imem_addr=0, captured req_pc=0.
- FSM states: IDLE, WAIT, DISCARD.
- Issue:
  - Condition: state==IDLE && count<DEPTH && !if_flush.
  - On issue, in the same cycle (combinational from registered state): imem_rd=1, imem_addr={if_pc[31:2],2'b00}, if_pc_we=1.
  - req_pc<=if_pc. Next state WAIT.
  - if_pc_we and imem_rd are never 1 outside an issue cycle.
- Outstanding requests: at most one. No issue while in WAIT or DISCARD.
- WAIT:
  - On imem_valid: push {req_pc, imem_dout} into FIFO, then go to IDLE.
  - The slot is guaranteed free because issue required count<DEPTH and no other push is possible.
  - Memory latency is arbitrary (>=1 cycle). imem_valid in IDLE is ignored.
- Throughput: at most one instruction per 2 cycles with 1-cycle memory.
- Pop: when ir_valid && ir_ready, read pointer increments and count decrements.
  - Push and pop in the same cycle leave count unchanged.
- ir_valid = (count!=0).
- ir and ir_pc reflect the head entry combinationally from FIFO storage. Values are don't-care when ir_valid=0 but must not be X after reset.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Flush (if_flush=1), which has priority over push, pop and issue:
  - count<=0 and pointers<=0 next cycle. No issue that cycle. A coincident pop is dropped.
  - If state==WAIT and imem_valid is not asserted this cycle, go to DISCARD. If imem_valid is asserted, drop the word and go to IDLE.
  - In DISCARD: wait for imem_valid, drop the word, then go to IDLE.
  - Flush in DISCARD stays in DISCARD.
  - First post-flush issue occurs in the cycle after the FSM reaches IDLE with if_flush low, using the redirected if_pc.
- Reset mid-operation: an in-flight response arriving after reset is ignored, because state is IDLE after reset.
- No misalignment trap here. imem_addr is forced word-aligned; ir_pc carries the full PC.

Test Plan:
- Reset then free-run:
  - Stimulus: 1-cycle memory, ir_ready=1, if_pc stepping 0,4,8.
  - Required: imem_rd/if_pc_we pulse every 2nd cycle; ir_valid delivers ir_pc=0x0,0x4,0x8 in order with the matching words.
- Fill to full:
  - Stimulus: DEPTH=4, ir_ready=0.
  - Required: exactly 4 issues, then imem_rd and if_pc_we stay 0; count=4.
  - Then raise ir_ready for 1 cycle: one pop, and a new issue the following cycle.
- Simultaneous push and pop at count=2:
  - Required: count stays 2; ordering preserved.
- Flush while WAIT:
  - Stimulus: 3-cycle memory latency, flush 1 cycle after issue at pc=0x10.
  - Required: FIFO empties; response word 0xDEADBEEF is discarded; next issue uses redirected if_pc=0x80; first ir_pc out is 0x80.
- Flush coincident with imem_valid and ir_ready:
  - Required: no push, no pop, count=0, state=IDLE next cycle.
- Reset mid-WAIT:
  - Stimulus: if_rst while WAIT, then a late imem_valid arrives.
  - Required: all outputs return to reset values; the late word is not pushed; ir_valid stays 0.
